bram_sync_fifo: RTL and testbench

Single-clock, first-word-fall-through FIFO built from inferred block RAM, with parametrised data width and depth, a fill-level counter, programmable almost-full/almost-empty flags and a synchronous flush. It is the successor to the dual-clock BRAM FIFO and is used wherever producer and consumer share one clock, for example between the host interface and a packet processor. Accepted words have exactly defined latencies. Rejected accesses are flagged on the next cycle instead of being retried.

---
 rtl/bram_sync_fifo_pkg.sv | 22 ++
 rtl/bram_sync_fifo_if.sv | 35 +++
 rtl/bram_sdp.sv | 39 +++
 rtl/bram_sync_fifo.sv | 122 ++++++++++++
 tb/tb_bram_sync_fifo.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/bram_sync_fifo_pkg.sv
// Shared sizing helpers for the single-clock BRAM FIFO.
// Derived constants and parameter legality live here so every file agrees.
package bram_sync_fifo_pkg;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  function automatic int count_width(input int aw);
    return aw + 1;
  endfunction

  function automatic bit offsets_legal(
    input int depth,
    input int af,
    input int ae
  );
    return (af >= 1) && (af <= depth - 1) &&
           (ae >= 0) && (ae <= depth - 2);
  endfunction

endpackage

// File: rtl/bram_sync_fifo_if.sv
// Producer/consumer bundle of the single-clock BRAM FIFO.
// The FIFO takes the slave side; the user logic drives the master side.
interface bram_sync_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
);

  logic                  FLUSH;
  logic [DATA_WIDTH-1:0] DI;
  logic                  WREN;
  logic                  FULL;
  logic                  ALMOSTFULL;
  logic                  WRERR;
  logic [DATA_WIDTH-1:0] DO;
  logic                  EMPTY;
  logic                  ALMOSTEMPTY;
  logic                  RDEN;
  logic                  RDERR;
  logic [ADDR_WIDTH:0]   COUNT;

  modport master (
    output FLUSH, DI, WREN, RDEN,
    input  FULL, ALMOSTFULL, WRERR,
    input  DO, EMPTY, ALMOSTEMPTY,
    input  RDERR, COUNT
  );

  modport slave (
    input  FLUSH, DI, WREN, RDEN,
    output FULL, ALMOSTFULL, WRERR,
    output DO, EMPTY, ALMOSTEMPTY,
    output RDERR, COUNT
  );

endinterface

// File: rtl/bram_sdp.sv
// Simple dual-port block RAM with a registered, clearable read port.
// Callers guarantee read and write never target one address on one edge.
module bram_sdp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk_i,
  input  logic                  clr_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Output register reset maps onto the BRAM's own sync reset pin.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_sync_fifo.sv
// First-word-fall-through single-clock FIFO on inferred block RAM.
// The RAM read register doubles as the DO head-word register.
module bram_sync_fifo
  import bram_sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int AF_OFFSET  = 16,
  parameter int AE_OFFSET  = 16
) (
  input  logic                   CLK,
  input  logic                   reset,
  bram_sync_fifo_if.slave        bus
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam int CW    = count_width(ADDR_WIDTH);

  typedef logic [CW-1:0]         cnt_t;
  typedef logic [ADDR_WIDTH-1:0] ptr_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t AF_LVL  = cnt_t'(DEPTH - AF_OFFSET);
  localparam cnt_t AE_LVL  = cnt_t'(AE_OFFSET);

  generate
    if (!offsets_legal(DEPTH, AF_OFFSET, AE_OFFSET)) begin : g_bad_offsets
      $error("bram_sync_fifo: AF_OFFSET or AE_OFFSET out of range");
    end
  endgenerate

  logic clr;
  logic wr_acc;
  logic rd_acc;
  logic do_free;
  logic load;
  cnt_t ram_cnt;

  cnt_t cnt_q, cnt_d;
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  logic empty_q, empty_d;
  logic full_q, full_d;
  logic af_q, af_d;
  logic ae_q, ae_d;
  logic wrerr_q, wrerr_d;
  logic rderr_q, rderr_d;

  always_comb begin
    clr     = reset | bus.FLUSH;
    wr_acc  = bus.WREN & ~full_q & ~clr;
    rd_acc  = bus.RDEN & ~empty_q & ~clr;
    // COUNT includes the DO word; what is left sits in RAM.
    ram_cnt = cnt_q - {{ADDR_WIDTH{1'b0}}, ~empty_q};
    do_free = empty_q | rd_acc;
    load    = do_free & (ram_cnt != '0) & ~clr;

    wr_ptr_d = wr_ptr_q + ptr_t'(wr_acc);
    rd_ptr_d = rd_ptr_q + ptr_t'(load);

    cnt_d = cnt_q;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase

    empty_d = do_free ? ~load : 1'b0;
    full_d  = (cnt_d == DEPTH_C);
    af_d    = (cnt_d >= AF_LVL);
    ae_d    = (cnt_d <= AE_LVL);
    wrerr_d = bus.WREN & full_q & ~clr;
    rderr_d = bus.RDEN & empty_q & ~clr;
  end

  always_ff @(posedge CLK) begin
    if (clr) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      wrerr_q  <= 1'b0;
      rderr_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      wrerr_q  <= wrerr_d;
      rderr_q  <= rderr_d;
    end
  end

  bram_sdp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i   (CLK),
    .clr_i   (clr),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.DI),
    .re_i    (load),
    .raddr_i (rd_ptr_q),
    .rdata_o (bus.DO)
  );

  assign bus.COUNT       = cnt_q;
  assign bus.EMPTY       = empty_q;
  assign bus.FULL        = full_q;
  assign bus.ALMOSTFULL  = af_q;
  assign bus.ALMOSTEMPTY = ae_q;
  assign bus.WRERR       = wrerr_q;
  assign bus.RDERR       = rderr_q;

endmodule

// File: tb/tb_bram_sync_fifo.sv
// Scoreboard bench for bram_sync_fifo with a small DEPTH=64 build.
// A queue-based reference tracks the RAM words and the DO head word.
module tb_bram_sync_fifo;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;
  localparam int AFO   = 16;
  localparam int AEO   = 16;

  logic clk;
  logic rst;

  bram_sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  bram_sync_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AF_OFFSET  (AFO),
    .AE_OFFSET  (AEO)
  ) dut (
    .CLK   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  int          m_cnt;
  bit          m_dov;
  logic [31:0] m_do;
  bit          m_werr;
  bit          m_rerr;
  logic [31:0] m_ram[$];
  logic [31:0] sb[$];
  int          n_wr;
  int          n_rd;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_cnt  = 0;
    m_dov  = 0;
    m_do   = '0;
    m_werr = 0;
    m_rerr = 0;
    m_ram.delete();
    sb.delete();
  endtask

  task automatic check_all();
    check("count", 64'(bus.COUNT), 64'(m_cnt));
    check("empty", 64'(bus.EMPTY), 64'(!m_dov));
    check("full", 64'(bus.FULL), 64'(m_cnt == DEPTH));
    check("afull", 64'(bus.ALMOSTFULL), 64'(m_cnt >= DEPTH - AFO));
    check("aempty", 64'(bus.ALMOSTEMPTY), 64'(m_cnt <= AEO));
    check("wrerr", 64'(bus.WRERR), 64'(m_werr));
    check("rderr", 64'(bus.RDERR), 64'(m_rerr));
    check("do", 64'(bus.DO), 64'(m_do));
  endtask

  task automatic cyc(input bit we, input logic [31:0] d,
                     input bit re, input bit fl);
    bit wacc;
    bit racc;
    bus.WREN  = we;
    bus.DI    = d;
    bus.RDEN  = re;
    bus.FLUSH = fl;
    wacc = we && !fl && (m_cnt < DEPTH);
    racc = re && !fl && m_dov;
    if (racc) begin
      if (sb.size() == 0) check("sb_underflow", 64'd1, 64'd0);
      else check("rd_data", 64'(bus.DO), 64'(sb.pop_front()));
      n_rd++;
    end
    @(posedge clk);
    #1;
    if (fl) begin
      model_clear();
    end else begin
      m_werr = we && !wacc;
      m_rerr = re && !m_dov;
      if (!m_dov || racc) begin
        if (m_ram.size() > 0) begin
          m_do  = m_ram.pop_front();
          m_dov = 1;
        end else begin
          m_dov = 0;
        end
      end
      if (wacc) begin
        m_ram.push_back(d);
        sb.push_back(d);
        n_wr++;
      end
      m_cnt = m_cnt + int'(wacc) - int'(racc);
    end
    check_all();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.WREN  = 1'b1;
    bus.RDEN  = 1'b1;
    bus.FLUSH = 1'b0;
    bus.DI    = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    check_all();
  endtask

  initial begin
    int guard;
    checks   = 0;
    failures = 0;
    n_wr     = 0;
    n_rd     = 0;
    rst      = 1'b0;
    model_clear();
    do_reset();

    // first write: COUNT=1 after edge 0, DO valid after edge 1
    cyc(1, 32'h1111_1111, 0, 0);
    check("first_cnt", 64'(bus.COUNT), 64'd1);
    check("first_empty0", 64'(bus.EMPTY), 64'd1);
    cyc(0, 0, 0, 0);
    check("first_empty1", 64'(bus.EMPTY), 64'd0);
    check("first_do", 64'(bus.DO), 64'h1111_1111);
    cyc(0, 0, 1, 0);

    // fill to DEPTH, then one rejected write
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 32'h1000_0000 + i, 0, 0);
      if (i == DEPTH - 2) check("not_full_yet", 64'(bus.FULL), 64'd0);
    end
    check("full_at_depth", 64'(bus.FULL), 64'd1);
    cyc(1, 32'hBAD0_0000, 0, 0);
    check("wrerr_pulse", 64'(bus.WRERR), 64'd1);
    check("cnt_stays", 64'(bus.COUNT), 64'(DEPTH));
    cyc(0, 0, 0, 0);
    check("wrerr_single", 64'(bus.WRERR), 64'd0);

    // drain with RDEN held, plus one read on empty
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 1, 0);
    check("drain_rderr", 64'(bus.RDERR), 64'd1);
    check("drain_empty", 64'(bus.EMPTY), 64'd1);
    cyc(0, 0, 0, 0);
    check("rderr_single", 64'(bus.RDERR), 64'd0);

    // random stream across several pointer wraps
    n_wr  = 0;
    guard = 0;
    while (n_wr < 3 * DEPTH + 5 && guard < 20000) begin
      cyc(($urandom_range(0, 99) < 55), $urandom,
          ($urandom_range(0, 99) < 50), 0);
      guard++;
    end
    if (guard >= 20000) check("stream_bound", 64'd0, 64'd1);
    guard = 0;
    while (m_cnt > 0 && guard < 4 * DEPTH) begin
      cyc(0, 0, 1, 0);
      guard++;
    end
    check("stream_drained", 64'(bus.COUNT), 64'd0);
    check("wr_minus_rd", 64'(sb.size()), 64'd0);

    // flush with both requests asserted
    for (int i = 0; i < 40; i++) cyc(1, 32'h2000_0000 + i, 0, 0);
    check("pre_flush_cnt", 64'(bus.COUNT), 64'd40);
    cyc(1, 32'hFFFF_0000, 1, 1);
    check("flush_cnt", 64'(bus.COUNT), 64'd0);
    check("flush_empty", 64'(bus.EMPTY), 64'd1);
    cyc(1, 32'h3333_3333, 0, 0);
    check("flush_noerr", 64'(bus.WRERR | bus.RDERR), 64'd0);
    cyc(0, 0, 0, 0);
    check("post_flush_do", 64'(bus.DO), 64'h3333_3333);
    cyc(0, 0, 1, 0);

    // one word in DO, simultaneous read and write
    cyc(1, 32'h5A5A_5A5A, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 32'hA5A5_A5A5, 1, 0);
    check("sw_empty", 64'(bus.EMPTY), 64'd1);
    cyc(0, 0, 0, 0);
    check("sw_do", 64'(bus.DO), 64'hA5A5_A5A5);
    check("sw_valid", 64'(bus.EMPTY), 64'd0);
    cyc(0, 0, 1, 0);

    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
